// File: rtl/edge_event_capture.sv
// Per-bit edge detector for a sampled bus, with a timestamped event FIFO.
// Every enabled sample that differs from the previous enabled sample is
// queued as {rise, fall, ts} and drained through a valid/ready port.
module edge_event_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         din,
    output logic                     lsb_rose,
    output logic [WIDTH-1:0]         rise_mask,
    output logic [WIDTH-1:0]         fall_mask,
    output logic                     any_edge,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_rise,
    output logic [WIDTH-1:0]         out_fall,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic [TS_W-1:0]  ts;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [TS_W-1:0]  ts;

    logic [WIDTH-1:0] changed;
    logic             push;
    logic             pop;
    logic             full;
    logic             drop;
    logic             wr;

    assign changed   = din ^ prev;
    assign push      = en & primed & (|changed);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (level == FULL_LVL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign drop      = push & full & ~pop;
    assign wr        = push & ~drop;

    assign head     = mem[rptr];
    assign out_rise = head.rise;
    assign out_fall = head.fall;
    assign out_ts   = head.ts;

    // Free-running timestamp, previous-sample register and edge masks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts        <= '0;
            prev      <= '0;
            primed    <= 1'b0;
            rise_mask <= '0;
            fall_mask <= '0;
            lsb_rose  <= 1'b0;
            any_edge  <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (en && primed) begin
                rise_mask <= din & ~prev;
                fall_mask <= ~din & prev;
                lsb_rose  <= din[0] & ~prev[0];
                any_edge  <= |changed;
            end else begin
                rise_mask <= '0;
                fall_mask <= '0;
                lsb_rose  <= 1'b0;
                any_edge  <= 1'b0;
            end
            if (en) begin
                prev   <= din;
                primed <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Event storage; the slot being popped may be rewritten on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n && wr)
            mem[wptr] <= '{rise: din & ~prev, fall: ~din & prev, ts: ts};
    end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
- Synthesizable per-bit edge detector and event buffer for a multibit sampled bus.
- Sits directly downstream of the stimulus/bus under observation, in the same place an assertion checker sits. Covers the gap left by `$rose` on a vector, which reports only LSB transitions.
- Each sample cycle produces full rising and falling masks. An LSB-only rise flag matches `$rose` semantics.
- Every cycle with at least one edge is pushed, with a timestamp, into a small FIFO drained through a valid/ready handshake.

Parameters:
- WIDTH, 4, width of sampled bus din.
- DEPTH, 4, event FIFO entries; power of two, ≥2.
- TS_W, 8, timestamp counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  sample enable; din is sampled only on cycles with en=1.
- din  in  WIDTH  bus under observation.
- lsb_rose  out  1  registered; 1 when din[0] went 0→1 between consecutive samples.
- rise_mask  out  WIDTH  registered; per-bit 0→1 since the previous sample.
- fall_mask  out  WIDTH  registered; per-bit 1→0 since the previous sample.
- any_edge  out  1  registered; OR of rise_mask|fall_mask.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_rise  out  WIDTH  head entry rise mask.
- out_fall  out  WIDTH  head entry fall mask.
- out_ts  out  TS_W  head entry timestamp.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- clr_ovf  in  1  clears overflow.

Behaviour:
Reset (rst_n=0 at posedge) clears the following; reset mid-operation discards queued events:
- prev=0, primed=0, ts=0
- all masks and lsb_rose/any_edge = 0
- FIFO pointers and level = 0, out_valid=0
- overflow=0

Timestamp:
- ts increments every clock regardless of en, and wraps modulo 2^TS_W.
- An event carries the ts value of the posedge at which din was sampled.

Sampling (posedge with en=1):
- If primed=0: prev←din, primed←1, masks←0. The first sample after reset never reports edges.
- If primed=1:
  - rise_mask ← din & ~prev
  - fall_mask ← ~din & prev
  - lsb_rose ← din[0] & ~prev[0]
  - prev ← din
- Latency: masks are valid in the cycle following the sampling edge.

Enable low:
- Posedge with en=0: masks, lsb_rose and any_edge ← 0, and prev holds.
- Edges are measured across enabled samples only.
- en does not clear primed; only reset does.

X/Z handling:
- Not handled in RTL; the bench drives only known values.
- The bench may compare lsb_rose against a `$rose(din)` assertion.

Event push:
- At the sampling posedge, if primed=1, en=1 and (din ^ prev) ≠ 0, then {rise, fall, ts} is written.
- The entry is visible at the head (out_valid) no earlier than the next cycle.

Pop:
- Occurs at a posedge with out_valid=1 and out_ready=1.
- out_rise, out_fall and out_ts stay stable while out_valid=1 and out_ready=0.

Full:
- A push while level=DEPTH with no simultaneous pop is dropped and sets overflow.
- Push and pop in the same cycle while full both succeed and level is unchanged.

Empty:
- out_valid=0; out_ready is ignored.
- Push and pop in the same cycle while empty is push only; there is no bypass.

Overflow:
- clr_ovf=1 clears overflow.
- If clr_ovf and a drop occur in the same cycle, overflow remains 1.

Pointers: wrap modulo DEPTH; level = writes − reads.

Test Plan:
- Reset then en=1 every cycle; din sequence 1000, 1001, 1011, 1111, 1101 with out_ready=1.
  - Expect on the primed sample: no event.
  - Then rise=0001/fall=0000 (lsb_rose=1), rise=0010, rise=0100, fall=0010.
  - Four FIFO entries with consecutive ts values.
- din 0001 → 0011 (LSB stays 1).
  - Expect lsb_rose=0, rise_mask=0010, any_edge=1. This is the case `$rose` misses.
- out_ready=0, DEPTH=4, six toggling samples.
  - Expect level=4 and overflow=1.
  - Head is the first event.
  - Then with out_ready=1, exactly 4 entries drain in order.
- Full FIFO with out_ready=1 and a new edge in the same cycle.
  - Expect level stays 4, overflow unchanged, and the new entry lands at the tail.
- en=0 while din changes 0000→1111→0000, then en=1 with din=0101.
  - Expect no events during en=0.
  - Then rise=0101 relative to the last enabled sample 0000.
- Assert rst_n=0 with 3 entries queued.
  - Next cycle: out_valid=0, level=0, ts=0.
  - First post-reset sample produces no event.
